// File: rtl/i2c_reg_sequencer.sv
// Register-level I2C transaction sequencer: turns one (device, register, rd/wr, length) command
// into the byte sequence for a byte-level I2C master, buffering read data for the application.
module i2c_reg_sequencer #(
    parameter logic [6:0]  DEV_ADDR = 7'h77,
    parameter int          MAX_LEN  = 22,
    parameter int          LEN_W    = 5,
    parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_rd,
    input  logic             cmd_dev_sel,
    input  logic [6:0]       cmd_dev,
    input  logic [7:0]       cmd_reg,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [LEN_W-1:0] wr_idx,
    input  logic [7:0]       wr_data,
    input  logic [LEN_W-1:0] rd_idx,
    output logic [7:0]       rd_data,
    output logic             done,
    output logic             err,
    input  logic             mst_ready,
    output logic             mst_start,
    output logic             mst_stop,
    output logic             mst_send,
    output logic [7:0]       mst_txdata,
    input  logic             mst_sended,
    output logic             mst_receive,
    input  logic [7:0]       mst_rxdata,
    input  logic             mst_received,
    input  logic             mst_nack,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RDY, S_TX_LOAD, S_TX_WAIT, S_RX_WAIT, S_STOP, S_DONE
    } state_t;

    localparam logic [15:0]      TO_LAST = TIMEOUT - 16'd1;
    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

    state_t           state, state_next;
    logic             rd_q, start_q, err_q, abort;
    logic [6:0]       dev_q;
    logic [7:0]       reg_q, tx_q;
    logic [LEN_W-1:0] len_q, cnt, len_m1;
    logic [1:0]       phase;
    logic [15:0]      timer;
    logic             prev_sended, prev_received, sended_ev, received_ev;
    logic             bad_len, last_tx, timed_out, waiting;
    logic [7:0]       buffer [MAX_LEN];

    assign sended_ev   = mst_sended && !prev_sended;
    assign received_ev = mst_received && !prev_received;
    assign len_m1      = len_q - ONE_L;
    assign bad_len     = (cmd_len > MAX_L) || (cmd_rd && cmd_len == '0);
    assign timed_out   = timer >= TO_LAST;
    assign waiting     = (state == S_WAIT_RDY) || (state == S_TX_WAIT) || (state == S_RX_WAIT);
    // Phase 0 = ADDR+W, 1 = REG, 2 = write data bytes or the ADDR+R of a read.
    assign last_tx     = (phase == 2'd1 && !rd_q && len_q == '0) ||
                         (phase == 2'd2 && (rd_q || cnt == len_m1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        abort      = 1'b0;
        case (state)
            S_IDLE:     if (cmd_valid) state_next = bad_len ? S_DONE : S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (mst_ready)      state_next = S_TX_LOAD;
                else if (timed_out) begin state_next = S_STOP; abort = 1'b1; end
            end
            S_TX_LOAD:  state_next = S_TX_WAIT;
            S_TX_WAIT: begin
                if (sended_ev) begin
                    if (mst_nack)     begin state_next = S_STOP; abort = 1'b1; end
                    else if (last_tx) state_next = rd_q ? S_RX_WAIT : S_STOP;
                    else              state_next = S_TX_LOAD;
                end else if (timed_out) begin
                    state_next = S_STOP;
                    abort      = 1'b1;
                end
            end
            S_RX_WAIT: begin
                if (received_ev) begin
                    if (cnt == len_m1) state_next = S_STOP;
                end else if (timed_out) begin
                    state_next = S_STOP;
                    abort      = 1'b1;
                end
            end
            S_STOP:     state_next = S_DONE;
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = (state == S_IDLE);
        mst_send    = (state == S_TX_WAIT);
        mst_start   = (state == S_TX_WAIT) && start_q;
        mst_receive = (state == S_RX_WAIT);
        mst_stop    = (state == S_STOP);
        done        = (state == S_DONE);
        err         = err_q;
        mst_txdata  = tx_q;
        wr_idx      = cnt;
        dbg_state   = state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_sended   <= 1'b0;
            prev_received <= 1'b0;
            timer         <= '0;
        end else begin
            prev_sended   <= mst_sended;
            prev_received <= mst_received;
            if (state_next != state || sended_ev || received_ev) timer <= '0;
            else if (waiting)                                    timer <= timer + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q    <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            len_q   <= '0;
            cnt     <= '0;
            phase   <= '0;
            tx_q    <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) buffer[i] <= 8'h00;
        end else begin
            if (state == S_IDLE && cmd_valid) begin
                rd_q  <= cmd_rd;
                dev_q <= cmd_dev_sel ? cmd_dev : DEV_ADDR;
                reg_q <= cmd_reg;
                len_q <= cmd_len;
                cnt   <= '0;
                phase <= '0;
                err_q <= bad_len;
            end
            if (state == S_TX_LOAD) begin
                case (phase)
                    2'd0:    begin tx_q <= {dev_q, 1'b0}; start_q <= 1'b1; end
                    2'd1:    begin tx_q <= reg_q;         start_q <= 1'b0; end
                    default: begin tx_q <= rd_q ? {dev_q, 1'b1} : wr_data; start_q <= rd_q; end
                endcase
            end
            if (state == S_TX_WAIT && sended_ev && !mst_nack) begin
                if (phase != 2'd2) phase <= phase + 2'd1;
                else if (!rd_q)    cnt   <= cnt + ONE_L;
            end
            if (state == S_RX_WAIT && received_ev) begin
                buffer[cnt] <= mst_rxdata;
                cnt         <= cnt + ONE_L;
            end
            if (abort) err_q <= 1'b1;
        end
    end

    assign rd_data = (rd_idx < MAX_L) ? buffer[rd_idx] : 8'h00;

endmodule
